// File: rtl/mul_sequencer.sv
// Iterative shift-add multiply sequencer for the EX stage: runs one EXE_MUL over
// up to WIDTH cycles, freezing the front of the pipe, then strobes the low product word.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no multiply in flight; a valid EXE_MUL in EX starts one
// BUSY  | one shift-add step per cycle; pipeline frozen
// DONE  | result/nz presented with result_valid; MUL leaves EX this edge
module mul_sequencer #(
  parameter int         WIDTH   = 32,
  parameter int         CNT_W   = 6,
  parameter logic [3:0] EXE_MUL = 4'h2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [3:0]       exe_cmd,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             freeze,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [1:0]       nz
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mult_q, mult_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [1:0]         nz_q, nz_d;
  logic               result_valid_q, result_valid_d;

  logic               start;
  logic               last_iter;
  logic [WIDTH-1:0]   acc_sum;

  always_comb begin
    // rst_n gates start so a held MUL in EX cannot raise freeze during reset
    start     = rst_n && (state_q == IDLE) && ex_valid && (exe_cmd == EXE_MUL) && !flush;
    acc_sum   = acc_q + (mult_q[0] ? mcand_q : '0);
    last_iter = (mult_q[WIDTH-1:1] == '0) || (count_q == CNT_W'(WIDTH - 1));
    freeze    = start || ((state_q == BUSY) && !flush);

    state_d        = state_q;
    acc_d          = acc_q;
    mcand_d        = mcand_q;
    mult_d         = mult_q;
    count_d        = count_q;
    result_d       = result_q;
    nz_d           = 2'b00;
    result_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = op_a;
          mult_d  = op_b;
          acc_d   = '0;
          count_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          acc_d   = '0;
          mcand_d = '0;
          mult_d  = '0;
          count_d = '0;
          state_d = IDLE;
        end else begin
          acc_d   = acc_sum;
          mcand_d = mcand_q << 1;
          mult_d  = mult_q >> 1;
          count_d = count_q + CNT_W'(1);
          if (last_iter) begin
            state_d        = DONE;
            result_d       = acc_sum;
            nz_d           = {acc_sum[WIDTH-1], (acc_sum == '0)};
            result_valid_d = 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      mcand_q        <= '0;
      mult_q         <= '0;
      count_q        <= '0;
      result_q       <= '0;
      nz_q           <= 2'b00;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      mcand_q        <= mcand_d;
      mult_q         <= mult_d;
      count_q        <= count_d;
      result_q       <= result_d;
      nz_q           <= nz_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign result       = result_q;
  assign nz           = nz_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed corner cases plus random
// operands compared against a plain-arithmetic product and timing model.
module tb_mul_sequencer;

  localparam logic [3:0] MUL_CMD = 4'h2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [3:0]  exe_cmd;
  logic        flush;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        freeze;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic [1:0]  nz;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] last_p   = 32'h0;

  always #5 clk = ~clk;

  mul_sequencer #(.WIDTH(32), .CNT_W(6), .EXE_MUL(MUL_CMD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .exe_cmd      (exe_cmd),
    .flush        (flush),
    .op_a         (op_a),
    .op_b         (op_b),
    .freeze       (freeze),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .nz           (nz)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic int msb_idx(input logic [31:0] b);
    int k = 0;
    for (int i = 0; i < 32; i++) if (b[i]) k = i;
    return k;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_freeze"}, 32'(freeze), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_rv"}, 32'(result_valid), 32'h0);
    chk({tag, "_result"}, result, 32'h0);
    chk({tag, "_nz"}, 32'(nz), 32'h0);
  endtask

  // Issues one MUL in the cycle after the next rising edge and follows it to DONE.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int          n;
    p = {32'h0, a} * {32'h0, b};
    n = msb_idx(b) + 1;
    @(posedge clk); #1;
    ex_valid = 1'b1; exe_cmd = MUL_CMD; flush = 1'b0; op_a = a; op_b = b;
    for (int c = 0; c <= n + 1; c++) begin
      @(negedge clk);
      chk("freeze", 32'(freeze), 32'(c <= n));
      chk("busy", 32'(busy), 32'(c >= 1));
      chk("result_valid", 32'(result_valid), 32'(c == n + 1));
      if (c == n + 1) begin
        chk("result", result, p[31:0]);
        chk("nz", 32'(nz), {30'h0, p[31], (p[31:0] == 32'h0)});
      end
      // operands may change behind a frozen stage; the multiply must use the latched ones
      if (c >= 1) begin op_a = $urandom; op_b = $urandom; end
    end
    last_p = p[31:0];
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    ex_valid = 1'b0; flush = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_freeze", 32'(freeze), 32'h0);
      chk("idle_rv", 32'(result_valid), 32'h0);
      chk("idle_nz", 32'(nz), 32'h0);
      chk("result_hold", result, last_p);
    end
  endtask

  // Starts a long MUL, then kills it at T5 with either flush or reset.
  task automatic abort_mul(input bit use_reset);
    bit seen_rv = 1'b0;
    @(posedge clk); #1;
    ex_valid = 1'b1; exe_cmd = MUL_CMD; flush = 1'b0;
    op_a = $urandom; op_b = 32'h8000_0000;
    repeat (5) @(posedge clk);
    #1;
    if (!use_reset) begin
      flush = 1'b1;
      #1;
      chk("flush_freeze", 32'(freeze), 32'h0);
      chk("flush_busy", 32'(busy), 32'h1);
      @(posedge clk); #1;
      flush = 1'b0; ex_valid = 1'b0;
      chk("flush_idle_busy", 32'(busy), 32'h0);
      chk("flush_idle_freeze", 32'(freeze), 32'h0);
    end else begin
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      ex_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      last_p = 32'h0;
      #1;
      chk_all_zero("rst_rel");
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (result_valid) seen_rv = 1'b1;
    end
    chk(use_reset ? "rst_no_rv" : "flush_no_rv", 32'(seen_rv), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    rst_n = 1'b0; ex_valid = 1'b0; exe_cmd = 4'h0; flush = 1'b0; op_a = '0; op_b = '0;
    #12;
    chk_all_zero("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_all_zero("after_reset");

    run_mul(32'd3, 32'd5);                 idle(2);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF); idle(2);
    run_mul(32'd7, 32'd0);                 idle(2);
    run_mul(32'hFFFF_FFFD, 32'd4);         idle(2);

    abort_mul(1'b0);
    abort_mul(1'b1);

    run_mul(32'd2, 32'd3);
    run_mul(32'd4, 32'd5);
    idle(2);

    // flush coincident with start, and a non-MUL command, must not start
    @(posedge clk); #1;
    ex_valid = 1'b1; exe_cmd = MUL_CMD; flush = 1'b1; op_a = 32'd9; op_b = 32'd9;
    #1;
    chk("flush_start_freeze", 32'(freeze), 32'h0);
    @(posedge clk); #1;
    flush = 1'b0; exe_cmd = MUL_CMD + 4'd1;
    chk("flush_start_busy", 32'(busy), 32'h0);
    chk("other_cmd_freeze", 32'(freeze), 32'h0);
    @(posedge clk); #1;
    chk("other_cmd_busy", 32'(busy), 32'h0);
    idle(1);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      run_mul(a, b);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
